// File: rtl/lock_pkg.sv
// Shared types and widths for the keypad lock: entry FSM states, digit/position widths,
// and the default primary/secondary code lengths.
package lock_pkg;
  localparam int DIGIT_W     = 4;
  localparam int POS_W       = 3;
  localparam int DEF_PRI_LEN = 4;
  localparam int DEF_SEC_LEN = 5;

  typedef enum logic [2:0] {
    ENTRY,
    EVAL,
    VERDICT,
    OPEN,
    LOCKOUT
  } state_t;
endpackage

// File: rtl/lock_timer.sv
// Load / count-down / done timer. done is high while the count is zero,
// so a load of N-1 followed by N enabled cycles ends with done asserted.
module lock_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/code_entry_seq.sv
// Keypad entry sequencer: presents digits to the comparator bank, accumulates verdicts,
// tracks failures/alarm/lockout. Optional inter-digit timeout under CODE_TIMEOUT_EN.
module code_entry_seq
  import lock_pkg::*;
#(
  parameter int PRI_LEN        = DEF_PRI_LEN,
  parameter int SEC_LEN        = DEF_SEC_LEN,
  parameter int MAX_TRIES      = 3,
  parameter int OPEN_CYCLES    = 8,
  parameter int LOCK_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_valid_i,
  input  logic [DIGIT_W-1:0] key_code_i,
  input  logic               key_clr_i,
  output logic               key_ready_o,
  input  logic               match_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic [POS_W-1:0]   pos_o,
  output logic               alarm_o,
  output logic               unlock_o,
  output logic               lockout_o,
  output logic [1:0]         fail_cnt_o,
  output state_t             state_o
);
  localparam int OW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t             state, state_nx;
  logic [POS_W-1:0]   pos_q, pos_nx;
  logic [DIGIT_W-1:0] digit_q, digit_nx;
  logic               err_q, err_nx;
  logic [1:0]         fail_q, fail_nx;
  logic               alarm_q, alarm_nx;
  logic               open_done, lock_done, timed_out;
  logic               tmr_load, to_load;
  logic [POS_W-1:0]   last_pos;

  assign last_pos = alarm_q ? POS_W'(SEC_LEN - 1) : POS_W'(PRI_LEN - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ENTRY;
      pos_q   <= '0;
      digit_q <= '0;
      err_q   <= 1'b0;
      fail_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      state   <= state_nx;
      pos_q   <= pos_nx;
      digit_q <= digit_nx;
      err_q   <= err_nx;
      fail_q  <= fail_nx;
      alarm_q <= alarm_nx;
    end
  end

  // Handshake: key_valid_i is a one-cycle strobe taken only while key_ready_o is high;
  // strobes seen while key_ready_o is low are dropped, never held for later.
  always_comb begin
    state_nx    = state;
    pos_nx      = pos_q;
    digit_nx    = digit_q;
    err_nx      = err_q;
    fail_nx     = fail_q;
    alarm_nx    = alarm_q;
    key_ready_o = 1'b0;
    tmr_load    = 1'b0;
    to_load     = 1'b0;
    case (state)
      ENTRY: begin
        key_ready_o = 1'b1;
        if (key_clr_i) begin
          pos_nx = '0;
          err_nx = 1'b0;
        end else if (timed_out) begin
          err_nx   = 1'b1;
          state_nx = VERDICT;
        end else if (key_valid_i) begin
          digit_nx = key_code_i;
          state_nx = EVAL;
        end
      end
      EVAL: begin
        to_load = 1'b1;
        if (key_clr_i) begin
          pos_nx   = '0;
          err_nx   = 1'b0;
          state_nx = ENTRY;
        end else begin
          err_nx = err_q | ~match_i;
          if (pos_q == last_pos) state_nx = VERDICT;
          else begin
            pos_nx   = pos_q + 1'b1;
            state_nx = ENTRY;
          end
        end
      end
      VERDICT: begin
        tmr_load = 1'b1;
        pos_nx   = '0;
        err_nx   = 1'b0;
        if (!err_q) begin
          fail_nx  = '0;
          alarm_nx = 1'b0;
          state_nx = OPEN;
        end else if (!alarm_q) begin
          // The failure that reaches MAX_TRIES flips to alarm instead of being displayed.
          if (fail_q == 2'(MAX_TRIES - 1)) begin
            alarm_nx = 1'b1;
            fail_nx  = '0;
          end else begin
            fail_nx = fail_q + 1'b1;
          end
          state_nx = ENTRY;
        end else begin
          state_nx = LOCKOUT;
        end
      end
      OPEN:    if (open_done) state_nx = ENTRY;
      LOCKOUT: if (lock_done) state_nx = ENTRY;
      default: state_nx = ENTRY;
    endcase
  end

  lock_timer #(.W(OW)) u_open_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (OW'(OPEN_CYCLES - 1)),
    .en       (state == OPEN),
    .done     (open_done)
  );

  lock_timer #(.W(LW)) u_lock_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (LW'(LOCK_CYCLES - 1)),
    .en       (state == LOCKOUT),
    .done     (lock_done)
  );

`ifdef CODE_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic to_done;

  // Reloaded on every accepted key; only meaningful once a partial entry exists.
  lock_timer #(.W(TW)) u_idle_tmr (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TW'(TIMEOUT_CYCLES - 1)),
    .en       (state == ENTRY),
    .done     (to_done)
  );

  assign timed_out = (state == ENTRY) && (pos_q != '0) && !key_valid_i && to_done;
`else
  logic unused_to;
  assign unused_to = to_load ^ (TIMEOUT_CYCLES != 0);
  assign timed_out = 1'b0;
`endif

  assign digit_o    = digit_q;
  assign pos_o      = pos_q;
  assign alarm_o    = alarm_q;
  assign fail_cnt_o = fail_q;
  assign unlock_o   = (state == OPEN);
  assign lockout_o  = (state == LOCKOUT);
  assign state_o    = state;
endmodule

// File: tb/tb_code_entry_seq.sv
// Scoreboard bench for code_entry_seq: directed key sequences against a bench-side comparator
// holding primary 1-2-3-4 and secondary 9-8-7-6-5.
module tb_code_entry_seq;
  import lock_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid_i;
  logic [3:0] key_code_i;
  logic       key_clr_i;
  logic       key_ready_o;
  logic       match_i;
  logic [3:0] digit_o;
  logic [2:0] pos_o;
  logic       alarm_o;
  logic       unlock_o;
  logic       lockout_o;
  logic [1:0] fail_cnt_o;
  state_t     state_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] pres_q[$];   // {alarm, pos, digit} expected at each EVAL
  logic [8:0] pulse_q[$];  // {kind (0 unlock, 1 lockout), length}

  always #5 clk = ~clk;

  code_entry_seq dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid_i (key_valid_i),
    .key_code_i  (key_code_i),
    .key_clr_i   (key_clr_i),
    .key_ready_o (key_ready_o),
    .match_i     (match_i),
    .digit_o     (digit_o),
    .pos_o       (pos_o),
    .alarm_o     (alarm_o),
    .unlock_o    (unlock_o),
    .lockout_o   (lockout_o),
    .fail_cnt_o  (fail_cnt_o),
    .state_o     (state_o)
  );

  // Comparator bank model
  function automatic logic cmp(input logic a, input logic [2:0] p, input logic [3:0] d);
    logic [3:0] pri [4];
    logic [3:0] sec [5];
    pri = '{4'd1, 4'd2, 4'd3, 4'd4};
    sec = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5};
    if (a) return (p < 3'd5) ? (d == sec[p]) : 1'b0;
    return (p < 3'd4) ? (d == pri[p[1:0]]) : 1'b0;
  endfunction

  assign match_i = cmp(alarm_o, pos_o, digit_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!key_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(key_ready_o), 32'd1);
  endtask

  task automatic press(input logic [3:0] d, input logic [2:0] p, input logic a);
    wait_ready();
    pres_q.push_back({a, p, d});
    key_valid_i = 1'b1;
    key_code_i  = d;
    @(negedge clk);
    key_valid_i = 1'b0;
  endtask

  // Called right after the last digit's EVAL cycle of a correct code.
  task automatic expect_unlock();
    pulse_q.push_back({1'b0, 8'd8});
    @(negedge clk);
    chk("verdict_state", 32'(state_o), 32'(VERDICT));
    chk("unlock_pre", 32'(unlock_o), 32'd0);
    @(negedge clk);
    chk("unlock_start", 32'(unlock_o), 32'd1);
    wait_ready();
  endtask

  // Primary attempt with a wrong digit at pos 2; returns in ENTRY after VERDICT.
  task automatic bad_primary();
    press(4'd1, 3'd0, 1'b0);
    press(4'd2, 3'd1, 1'b0);
    press(4'd0, 3'd2, 1'b0);
    press(4'd4, 3'd3, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: digit presentation and output pulse lengths
  int ucnt = 0;
  int lcnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (state_o == EVAL) begin
        if (pres_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL present unexpected pos=%0d digit=%0d", pos_o, digit_o);
        end else begin
          chk("present", {24'd0, alarm_o, pos_o, digit_o}, {24'd0, pres_q.pop_front()});
        end
      end
      if (unlock_o) ucnt++;
      else if (ucnt > 0) begin
        if (pulse_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unlock_pulse unexpected len=%0d", ucnt);
        end else chk("unlock_pulse", {23'd0, 1'b0, 8'(ucnt)}, {23'd0, pulse_q.pop_front()});
        ucnt = 0;
      end
      if (lockout_o) lcnt++;
      else if (lcnt > 0) begin
        if (pulse_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL lockout_pulse unexpected len=%0d", lcnt);
        end else chk("lockout_pulse", {23'd0, 1'b1, 8'(lcnt)}, {23'd0, pulse_q.pop_front()});
        lcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_valid_i = 1'b0;
    key_code_i = '0;
    key_clr_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    chk("rst_ready", 32'(key_ready_o), 32'd1);
    chk("rst_outs", {26'd0, unlock_o, lockout_o, alarm_o, fail_cnt_o, 1'b0}, 32'd0);
    chk("rst_pos", 32'(pos_o), 32'd0);
    chk("rst_digit", 32'(digit_o), 32'd0);
    chk("rst_state", 32'(state_o), 32'(ENTRY));

    // Correct primary code
    press(4'd1, 3'd0, 1'b0);
    press(4'd2, 3'd1, 1'b0);
    press(4'd3, 3'd2, 1'b0);
    press(4'd4, 3'd3, 1'b0);
    expect_unlock();
    chk("fail_after_open", 32'(fail_cnt_o), 32'd0);

    // Three primary failures raise alarm
    bad_primary();
    chk("fail_1", 32'(fail_cnt_o), 32'd1);
    bad_primary();
    chk("fail_2", 32'(fail_cnt_o), 32'd2);
    bad_primary();
    chk("alarm_set", 32'(alarm_o), 32'd1);
    chk("fail_wrap", 32'(fail_cnt_o), 32'd0);
    chk("pos_after_fail", 32'(pos_o), 32'd0);

    // Correct secondary code clears alarm
    press(4'd9, 3'd0, 1'b1);
    press(4'd8, 3'd1, 1'b1);
    press(4'd7, 3'd2, 1'b1);
    press(4'd6, 3'd3, 1'b1);
    press(4'd5, 3'd4, 1'b1);
    expect_unlock();
    chk("alarm_cleared", 32'(alarm_o), 32'd0);

    // Back to alarm, then failed secondary -> lockout
    bad_primary();
    bad_primary();
    bad_primary();
    chk("alarm_again", 32'(alarm_o), 32'd1);
    press(4'd9, 3'd0, 1'b1);
    press(4'd8, 3'd1, 1'b1);
    press(4'd7, 3'd2, 1'b1);
    press(4'd6, 3'd3, 1'b1);
    press(4'd0, 3'd4, 1'b1);
    pulse_q.push_back({1'b1, 8'd16});
    @(negedge clk);
    @(negedge clk);
    chk("lockout_on", 32'(lockout_o), 32'd1);
    chk("lock_ready", 32'(key_ready_o), 32'd0);
    key_valid_i = 1'b1;
    key_code_i = 4'd9;
    repeat (3) @(negedge clk);
    key_valid_i = 1'b0;
    chk("lock_pos", 32'(pos_o), 32'd0);
    chk("lock_state", 32'(state_o), 32'(LOCKOUT));
    wait_ready();
    chk("alarm_after_lock", 32'(alarm_o), 32'd1);
    chk("pos_after_lock", 32'(pos_o), 32'd0);

    // Leave alarm with the secondary code
    press(4'd9, 3'd0, 1'b1);
    press(4'd8, 3'd1, 1'b1);
    press(4'd7, 3'd2, 1'b1);
    press(4'd6, 3'd3, 1'b1);
    press(4'd5, 3'd4, 1'b1);
    expect_unlock();

    // Clear after two digits, colliding with a key strobe
    press(4'd1, 3'd0, 1'b0);
    press(4'd2, 3'd1, 1'b0);
    wait_ready();
    key_valid_i = 1'b1;
    key_clr_i = 1'b1;
    key_code_i = 4'd3;
    @(negedge clk);
    key_valid_i = 1'b0;
    key_clr_i = 1'b0;
    chk("clr_state", 32'(state_o), 32'(ENTRY));
    chk("clr_pos", 32'(pos_o), 32'd0);
    chk("clr_fail", 32'(fail_cnt_o), 32'd0);
    press(4'd1, 3'd0, 1'b0);
    press(4'd2, 3'd1, 1'b0);
    press(4'd3, 3'd2, 1'b0);
    press(4'd4, 3'd3, 1'b0);
    expect_unlock();

    // One digit then idle
    press(4'd1, 3'd0, 1'b0);
    repeat (32) @(negedge clk);
    chk("idle_32_state", 32'(state_o), 32'(ENTRY));
    chk("idle_32_pos", 32'(pos_o), 32'd1);
    @(negedge clk);
`ifdef CODE_TIMEOUT_EN
    chk("timeout_verdict", 32'(state_o), 32'(VERDICT));
    @(negedge clk);
    chk("timeout_fail", 32'(fail_cnt_o), 32'd1);
    chk("timeout_pos", 32'(pos_o), 32'd0);
`else
    repeat (8) @(negedge clk);
    chk("no_timeout_state", 32'(state_o), 32'(ENTRY));
    chk("no_timeout_pos", 32'(pos_o), 32'd1);
    chk("no_timeout_fail", 32'(fail_cnt_o), 32'd0);
`endif

    repeat (4) @(negedge clk);
    chk("pres_q_empty", 32'(pres_q.size()), 32'd0);
    chk("pulse_q_empty", 32'(pulse_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
